// File: rtl/hall_speed_estimator.sv
// Two-motor speed estimator: samples hall position counts once per window and reports edges per window.
// Optional window-to-window averaging of the reported speed is enabled with `define HALL_SPEED_AVG_EN.
module hall_speed_estimator #(
  parameter int unsigned WINDOW_CYCLES = 1000000,
  parameter int unsigned STALL_WINDOWS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        pos_clear,
  input  logic [15:0] pos1,
  input  logic [15:0] pos2,
  output logic [15:0] speed1,
  output logic [15:0] speed2,
  output logic        speed_valid,
  output logic        stall1,
  output logic        stall2,
  output logic [1:0]  dbg_state
);

  // speed_valid is a one-cycle strobe with no ready/backpressure: the consumer must
  // capture speed1/speed2 in the cycle speed_valid is high; the values then hold.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [31:0] LP_TC    = 32'(WINDOW_CYCLES - 1);
  localparam logic [7:0]  LP_STALL = 8'(STALL_WINDOWS);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_win_cnt;
  logic [15:0] r_prev1;
  logic [15:0] r_prev2;
  logic [7:0]  r_scnt1;
  logic [7:0]  r_scnt2;
  logic        w_tc;
  logic [15:0] w_delta1;
  logic [15:0] w_delta2;
  logic [15:0] w_out1;
  logic [15:0] w_out2;
  logic [7:0]  w_scnt_nxt1;
  logic [7:0]  w_scnt_nxt2;

  assign w_tc      = (r_win_cnt == LP_TC);
  assign w_delta1  = pos1 - r_prev1;
  assign w_delta2  = pos2 - r_prev2;
  assign dbg_state = r_state;

  // Stall counters saturate so the flag stays up for as long as the motor is still.
  assign w_scnt_nxt1 = (w_delta1 != 16'd0) ? 8'd0 :
                       (r_scnt1 == LP_STALL) ? r_scnt1 : r_scnt1 + 8'd1;
  assign w_scnt_nxt2 = (w_delta2 != 16'd0) ? 8'd0 :
                       (r_scnt2 == LP_STALL) ? r_scnt2 : r_scnt2 + 8'd1;

`ifdef HALL_SPEED_AVG_EN
  logic [15:0] r_last1;
  logic [15:0] r_last2;
  logic        r_first;
  logic [16:0] w_sum1;
  logic [16:0] w_sum2;

  // The first RUN window has no history, so it averages the delta with itself.
  assign w_sum1 = {1'b0, w_delta1} + {1'b0, (r_first ? w_delta1 : r_last1)};
  assign w_sum2 = {1'b0, w_delta2} + {1'b0, (r_first ? w_delta2 : r_last2)};
  assign w_out1 = 16'(w_sum1 >> 1);
  assign w_out2 = 16'(w_sum2 >> 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last1 <= 16'd0;
      r_last2 <= 16'd0;
      r_first <= 1'b1;
    end else if (en && !pos_clear && w_tc) begin
      if (r_state == PRIME) begin
        r_first <= 1'b1;
      end else if (r_state == RUN) begin
        r_last1 <= w_delta1;
        r_last2 <= w_delta2;
        r_first <= 1'b0;
      end
    end
  end
`else
  assign w_out1 = w_delta1;
  assign w_out2 = w_delta2;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!en) begin
      w_next_state = IDLE;
    end else if (pos_clear) begin
      w_next_state = PRIME;
    end else begin
      case (r_state)
        IDLE:    w_next_state = PRIME;
        PRIME:   if (w_tc) w_next_state = RUN;
        RUN:     w_next_state = RUN;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_win_cnt   <= 32'd0;
      r_prev1     <= 16'd0;
      r_prev2     <= 16'd0;
      r_scnt1     <= 8'd0;
      r_scnt2     <= 8'd0;
      speed1      <= 16'd0;
      speed2      <= 16'd0;
      speed_valid <= 1'b0;
      stall1      <= 1'b0;
      stall2      <= 1'b0;
    end else if (!en) begin
      r_win_cnt   <= 32'd0;
      r_scnt1     <= 8'd0;
      r_scnt2     <= 8'd0;
      speed_valid <= 1'b0;
      stall1      <= 1'b0;
      stall2      <= 1'b0;
    end else if (pos_clear) begin
      r_win_cnt   <= 32'd0;
      r_prev1     <= 16'd0;
      r_prev2     <= 16'd0;
      r_scnt1     <= 8'd0;
      r_scnt2     <= 8'd0;
      speed_valid <= 1'b0;
      stall1      <= 1'b0;
      stall2      <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      case (r_state)
        PRIME: begin
          if (w_tc) begin
            r_win_cnt <= 32'd0;
            r_prev1   <= pos1;
            r_prev2   <= pos2;
          end else begin
            r_win_cnt <= r_win_cnt + 32'd1;
          end
        end
        RUN: begin
          if (w_tc) begin
            r_win_cnt   <= 32'd0;
            r_prev1     <= pos1;
            r_prev2     <= pos2;
            speed1      <= w_out1;
            speed2      <= w_out2;
            speed_valid <= 1'b1;
            r_scnt1     <= w_scnt_nxt1;
            r_scnt2     <= w_scnt_nxt2;
            stall1      <= (w_scnt_nxt1 == LP_STALL);
            stall2      <= (w_scnt_nxt2 == LP_STALL);
          end else begin
            r_win_cnt <= r_win_cnt + 32'd1;
          end
        end
        default: r_win_cnt <= 32'd0;
      endcase
    end
  end

endmodule
